// File: rtl/axi4_mem_slave64.sv
// AXI4 slave backed by a dual-port synchronous RAM, 64-bit data.
// The write and read channels are independent, with one outstanding burst each.
// AWBURST/ARBURST are ignored: every burst is INCR over 64-bit words.
//
// state  | meaning
// W_INIT | leaving reset, all write-side outputs low
// W_IDLE | AWREADY high, waiting for a write address
// W_DATA | WREADY high, accepting exactly AWLEN+1 beats
// W_RESP | BVALID high until BREADY
// R_INIT | leaving reset, all read-side outputs low
// R_IDLE | ARREADY high, RAM read issued on the AR handshake
// R_LAT  | RAM output register filling
// R_DATA | RVALID high, RAM reads next word on each non-last handshake
module axi4_mem_slave64 #(
    parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
    parameter int          MEM_AW    = 12,
    parameter int          ID_W      = 1
) (
    input  logic            ACLK,
    input  logic            ARESETN,
    input  logic [ID_W-1:0] AWID,
    input  logic [31:0]     AWADDR,
    input  logic [7:0]      AWLEN,
    input  logic [2:0]      AWSIZE,
    input  logic [1:0]      AWBURST,
    input  logic            AWVALID,
    output logic            AWREADY,
    input  logic [63:0]     WDATA,
    input  logic [7:0]      WSTRB,
    input  logic            WLAST,
    input  logic            WVALID,
    output logic            WREADY,
    output logic [ID_W-1:0] BID,
    output logic [1:0]      BRESP,
    output logic            BVALID,
    input  logic            BREADY,
    input  logic [ID_W-1:0] ARID,
    input  logic [31:0]     ARADDR,
    input  logic [7:0]      ARLEN,
    input  logic [2:0]      ARSIZE,
    input  logic [1:0]      ARBURST,
    input  logic            ARVALID,
    output logic            ARREADY,
    output logic [ID_W-1:0] RID,
    output logic [63:0]     RDATA,
    output logic [1:0]      RRESP,
    output logic            RLAST,
    output logic            RVALID,
    input  logic            RREADY
);
    localparam int          DEPTH   = 1 << MEM_AW;
    localparam logic [31:0] DEPTH_W = DEPTH;

    typedef enum logic [1:0] {W_INIT, W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic [1:0] {R_INIT, R_IDLE, R_LAT, R_DATA} r_state_e;

    // Word index and below-base flag; 33-bit difference so a sub-base address never wraps.
    function automatic logic [32:0] addr_to_idx(input logic [31:0] addr);
        logic [32:0] diff;
        diff = {1'b0, addr} - {1'b0, ADDR_BASE};
        return {diff[32], diff[31:0] >> 3};
    endfunction

    logic [63:0] mem [DEPTH];
    logic [63:0] ram_q;

    w_state_e        w_state_q;
    logic            awready_q, wready_q, bvalid_q, werr_q, wbelow_q;
    logic [1:0]      bresp_q;
    logic [ID_W-1:0] bid_q;
    logic [31:0]     widx_q;
    logic [7:0]      wcnt_q;

    r_state_e        r_state_q;
    logic            arready_q, rvalid_q, rlast_q, roob_q, rbelow_q, rsize_err_q;
    logic [1:0]      rresp_q;
    logic [ID_W-1:0] rid_q;
    logic [31:0]     ridx_q;
    logic [7:0]      rcnt_q;

    logic        w_in_range, w_beat_err, wr_en;
    logic        ar_hs, r_adv, ram_rd_en, rd_below, rd_oob;
    logic [31:0] ram_rd_idx;
    logic [32:0] aw_idx, ar_idx;
    logic        unused_burst;

    assign unused_burst = ^{AWBURST, ARBURST};

    assign aw_idx     = addr_to_idx(AWADDR);
    assign ar_idx     = addr_to_idx(ARADDR);
    assign w_in_range = !wbelow_q && (widx_q < DEPTH_W);
    assign w_beat_err = !w_in_range || (WLAST != (wcnt_q == 8'd0));
    assign wr_en      = wready_q && WVALID && w_in_range;

    assign ar_hs = (r_state_q == R_IDLE) && ARVALID;
    assign r_adv = (r_state_q == R_DATA) && RREADY && !rlast_q;

    // RAM read address: burst start on AR handshake, otherwise the next word.
    always_comb begin
        ram_rd_en  = ar_hs || r_adv;
        ram_rd_idx = ar_hs ? ar_idx[31:0] : ridx_q + 32'd1;
        rd_below   = ar_hs ? ar_idx[32] : rbelow_q;
        rd_oob     = rd_below || (ram_rd_idx >= DEPTH_W);
    end

    // Dual-port RAM with byte enables; non-blocking read gives read-first behaviour.
    always_ff @(posedge ACLK) begin
        if (wr_en) begin
            for (int b = 0; b < 8; b++) begin
                if (WSTRB[b]) mem[widx_q[MEM_AW-1:0]][b*8 +: 8] <= WDATA[b*8 +: 8];
            end
        end
        if (ram_rd_en) ram_q <= mem[ram_rd_idx[MEM_AW-1:0]];
    end

    // Write channel FSM.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            w_state_q <= W_INIT;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            bid_q     <= '0;
            widx_q    <= '0;
            wbelow_q  <= 1'b0;
            wcnt_q    <= '0;
            werr_q    <= 1'b0;
        end else begin
            case (w_state_q)
                W_INIT: begin
                    awready_q <= 1'b1;
                    w_state_q <= W_IDLE;
                end
                W_IDLE: if (AWVALID) begin
                    bid_q     <= AWID;
                    widx_q    <= aw_idx[31:0];
                    wbelow_q  <= aw_idx[32];
                    wcnt_q    <= AWLEN;
                    werr_q    <= (AWSIZE != 3'b011);
                    awready_q <= 1'b0;
                    wready_q  <= 1'b1;
                    w_state_q <= W_DATA;
                end
                W_DATA: if (WVALID) begin
                    werr_q <= werr_q || w_beat_err;
                    widx_q <= widx_q + 32'd1;
                    wcnt_q <= wcnt_q - 8'd1;
                    if (wcnt_q == 8'd0) begin
                        wready_q  <= 1'b0;
                        bvalid_q  <= 1'b1;
                        bresp_q   <= (werr_q || w_beat_err) ? 2'b10 : 2'b00;
                        w_state_q <= W_RESP;
                    end
                end
                W_RESP: if (BREADY) begin
                    bvalid_q  <= 1'b0;
                    bresp_q   <= 2'b00;
                    awready_q <= 1'b1;
                    w_state_q <= W_IDLE;
                end
                default: w_state_q <= W_INIT;
            endcase
        end
    end

    // Read channel FSM.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state_q   <= R_INIT;
            arready_q   <= 1'b0;
            rvalid_q    <= 1'b0;
            rlast_q     <= 1'b0;
            rresp_q     <= 2'b00;
            rid_q       <= '0;
            ridx_q      <= '0;
            rbelow_q    <= 1'b0;
            roob_q      <= 1'b0;
            rcnt_q      <= '0;
            rsize_err_q <= 1'b0;
        end else begin
            case (r_state_q)
                R_INIT: begin
                    arready_q <= 1'b1;
                    r_state_q <= R_IDLE;
                end
                R_IDLE: if (ARVALID) begin
                    rid_q       <= ARID;
                    ridx_q      <= ram_rd_idx;
                    rbelow_q    <= rd_below;
                    roob_q      <= rd_oob;
                    rcnt_q      <= ARLEN;
                    rsize_err_q <= (ARSIZE != 3'b011);
                    arready_q   <= 1'b0;
                    r_state_q   <= R_LAT;
                end
                R_LAT: begin
                    rvalid_q  <= 1'b1;
                    rlast_q   <= (rcnt_q == 8'd0);
                    rresp_q   <= (rsize_err_q || roob_q) ? 2'b10 : 2'b00;
                    r_state_q <= R_DATA;
                end
                R_DATA: if (RREADY) begin
                    if (rlast_q) begin
                        rvalid_q  <= 1'b0;
                        rlast_q   <= 1'b0;
                        rresp_q   <= 2'b00;
                        arready_q <= 1'b1;
                        r_state_q <= R_IDLE;
                    end else begin
                        ridx_q  <= ram_rd_idx;
                        roob_q  <= rd_oob;
                        rcnt_q  <= rcnt_q - 8'd1;
                        rlast_q <= (rcnt_q == 8'd1);
                        rresp_q <= (rsize_err_q || rd_oob) ? 2'b10 : 2'b00;
                    end
                end
                default: r_state_q <= R_INIT;
            endcase
        end
    end

    assign AWREADY = awready_q;
    assign WREADY  = wready_q;
    assign BVALID  = bvalid_q;
    assign BRESP   = bresp_q;
    assign BID     = bid_q;
    assign ARREADY = arready_q;
    assign RVALID  = rvalid_q;
    assign RLAST   = rlast_q;
    assign RRESP   = rresp_q;
    assign RID     = rid_q;
    assign RDATA   = (rvalid_q && !roob_q) ? ram_q : 64'd0;

endmodule

// File: tb/tb_axi4_mem_slave64.sv
// Bench for axi4_mem_slave64: directed bursts plus randomized traffic checked
// against a word-array memory model.
module tb_axi4_mem_slave64;
    localparam int          ID_W  = 1;
    localparam int          DEPTH = 4096;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic            ACLK = 1'b0;
    logic            ARESETN = 1'b0;
    logic [ID_W-1:0] AWID = '0;
    logic [31:0]     AWADDR = '0;
    logic [7:0]      AWLEN = '0;
    logic [2:0]      AWSIZE = '0;
    logic [1:0]      AWBURST = '0;
    logic            AWVALID = 1'b0;
    logic            AWREADY;
    logic [63:0]     WDATA = '0;
    logic [7:0]      WSTRB = '0;
    logic            WLAST = 1'b0;
    logic            WVALID = 1'b0;
    logic            WREADY;
    logic [ID_W-1:0] BID;
    logic [1:0]      BRESP;
    logic            BVALID;
    logic            BREADY = 1'b0;
    logic [ID_W-1:0] ARID = '0;
    logic [31:0]     ARADDR = '0;
    logic [7:0]      ARLEN = '0;
    logic [2:0]      ARSIZE = '0;
    logic [1:0]      ARBURST = '0;
    logic            ARVALID = 1'b0;
    logic            ARREADY;
    logic [ID_W-1:0] RID;
    logic [63:0]     RDATA;
    logic [1:0]      RRESP;
    logic            RLAST;
    logic            RVALID;
    logic            RREADY = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [63:0] ref_mem [DEPTH];
    logic [63:0] wbuf [256];
    logic [7:0]  sbuf [256];

    axi4_mem_slave64 #(.ADDR_BASE(BASE), .MEM_AW(12), .ID_W(ID_W)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
    );

    always #5 ACLK = ~ACLK;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Word index of beat 'beat' of a burst at 'addr', or -1 when out of range.
    function automatic longint word_of(input logic [31:0] addr, input int beat);
        longint diff;
        diff = longint'(addr) - longint'(BASE);
        if (diff < 0) return -1;
        diff = (diff >>> 3) + longint'(beat);
        return (diff < DEPTH) ? diff : -1;
    endfunction

    task automatic do_write(input logic [31:0] addr, input int len, input logic [2:0] size,
                            input int bad_last, input logic [1:0] burst,
                            input logic [ID_W-1:0] id, input int gap_max, input string tag);
        int     n;
        bit     err, tmo;
        longint w;
        logic [1:0] exp_resp;
        err = (size != 3'd3);
        for (int i = 0; i <= len; i++) begin
            bit lastv;
            lastv = (bad_last >= 0) ? (i == bad_last) : (i == len);
            if (lastv != (i == len)) err = 1;
            w = word_of(addr, i);
            if (w < 0) err = 1;
            else for (int b = 0; b < 8; b++)
                if (sbuf[i][b]) ref_mem[w][b*8 +: 8] = wbuf[i][b*8 +: 8];
        end
        exp_resp = err ? 2'b10 : 2'b00;

        @(negedge ACLK);
        AWID = id; AWADDR = addr; AWLEN = 8'(len); AWSIZE = size; AWBURST = burst; AWVALID = 1'b1;
        n = 0;
        while (AWREADY !== 1'b1 && n < 200) begin @(negedge ACLK); n++; end
        chk({tag, "_aw_timeout"}, 64'(n >= 200), 64'd0);
        @(negedge ACLK);
        AWVALID = 1'b0;
        tmo = 0;
        for (int i = 0; i <= len && !tmo; i++) begin
            int gap;
            gap = $urandom_range(0, gap_max);
            WVALID = 1'b0;
            repeat (gap) @(negedge ACLK);
            WDATA = wbuf[i]; WSTRB = sbuf[i];
            WLAST = (bad_last >= 0) ? (i == bad_last) : (i == len);
            WVALID = 1'b1;
            n = 0;
            while (WREADY !== 1'b1 && n < 200) begin @(negedge ACLK); n++; end
            if (n >= 200) tmo = 1;
            @(negedge ACLK);
        end
        WVALID = 1'b0; WLAST = 1'b0;
        chk({tag, "_w_timeout"}, 64'(tmo), 64'd0);
        chk({tag, "_wready_after_last"}, 64'(WREADY), 64'd0);
        n = 0;
        while (BVALID !== 1'b1 && n < 200) begin @(negedge ACLK); n++; end
        chk({tag, "_b_timeout"}, 64'(n >= 200), 64'd0);
        repeat ($urandom_range(0, 2)) @(negedge ACLK);
        chk({tag, "_bvalid_held"}, 64'(BVALID), 64'd1);
        chk({tag, "_bresp"}, 64'(BRESP), 64'(exp_resp));
        chk({tag, "_bid"}, 64'(BID), 64'(id));
        BREADY = 1'b1;
        @(negedge ACLK);
        BREADY = 1'b0;
        chk({tag, "_bvalid_cleared"}, 64'(BVALID), 64'd0);
    endtask

    // mode 0: RREADY held high, 1: toggling starting high, 2: random.
    task automatic do_read(input logic [31:0] addr, input int len, input logic [2:0] size,
                           input logic [ID_W-1:0] id, input int mode, input int exp_lat,
                           input string tag);
        int          n, beats, cyc, first;
        logic        pvalid, pready, plast, rr;
        logic [63:0] pdata, edata;
        logic [1:0]  presp;
        longint      w;

        @(negedge ACLK);
        ARID = id; ARADDR = addr; ARLEN = 8'(len); ARSIZE = size;
        ARBURST = 2'($urandom_range(0, 3)); ARVALID = 1'b1;
        n = 0;
        while (ARREADY !== 1'b1 && n < 200) begin @(negedge ACLK); n++; end
        chk({tag, "_ar_timeout"}, 64'(n >= 200), 64'd0);
        @(negedge ACLK);
        ARVALID = 1'b0;
        beats = 0; cyc = 1; first = -1; pvalid = 0; pready = 0;
        pdata = '0; plast = 0; presp = '0;
        while (beats <= len && cyc < 3000) begin
            case (mode)
                0:       rr = 1'b1;
                1:       rr = (cyc % 2) == 1;
                default: rr = 1'($urandom_range(0, 1));
            endcase
            if (pvalid && !pready) begin
                chk($sformatf("%s_stall_valid_c%0d", tag, cyc), 64'(RVALID), 64'd1);
                chk($sformatf("%s_stall_data_c%0d", tag, cyc), RDATA, pdata);
                chk($sformatf("%s_stall_last_c%0d", tag, cyc), 64'(RLAST), 64'(plast));
                chk($sformatf("%s_stall_resp_c%0d", tag, cyc), 64'(RRESP), 64'(presp));
            end
            RREADY = rr;
            if (RVALID === 1'b1 && first < 0) first = cyc;
            if (RVALID === 1'b1 && rr) begin
                w = word_of(addr, beats);
                edata = (w < 0) ? 64'd0 : ref_mem[w];
                chk($sformatf("%s_b%0d_data", tag, beats), RDATA, edata);
                chk($sformatf("%s_b%0d_resp", tag, beats), 64'(RRESP),
                    (size != 3'd3 || w < 0) ? 64'd2 : 64'd0);
                chk($sformatf("%s_b%0d_last", tag, beats), 64'(RLAST), 64'(beats == len));
                chk($sformatf("%s_b%0d_id", tag, beats), 64'(RID), 64'(id));
                beats++;
            end
            pvalid = RVALID; pready = rr; pdata = RDATA; plast = RLAST; presp = RRESP;
            @(negedge ACLK);
            cyc++;
        end
        RREADY = 1'b0;
        chk({tag, "_r_timeout"}, 64'(beats <= len), 64'd0);
        chk({tag, "_rvalid_after_last"}, 64'(RVALID), 64'd0);
        if (exp_lat >= 0) chk({tag, "_latency"}, 64'(first), 64'(exp_lat));
    endtask

    initial begin
        int n;
        repeat (3) @(negedge ACLK);
        chk("rst_awready", 64'(AWREADY), 64'd0);
        chk("rst_arready", 64'(ARREADY), 64'd0);
        chk("rst_wready", 64'(WREADY), 64'd0);
        chk("rst_bvalid", 64'(BVALID), 64'd0);
        chk("rst_rvalid", 64'(RVALID), 64'd0);
        ARESETN = 1'b1;
        @(posedge ACLK);
        @(posedge ACLK);
        @(negedge ACLK);
        chk("rel_awready", 64'(AWREADY), 64'd1);
        chk("rel_arready", 64'(ARREADY), 64'd1);
        chk("rel_bvalid", 64'(BVALID), 64'd0);
        chk("rel_rvalid", 64'(RVALID), 64'd0);

        // 256-beat write/read with AWBURST=WRAP (ignored).
        for (int i = 0; i < 256; i++) begin wbuf[i] = 64'(i); sbuf[i] = 8'hFF; end
        do_write(32'h0, 255, 3'd3, -1, 2'b10, 1'b1, 0, "t2_wr");
        do_read(32'h0, 255, 3'd3, 1'b1, 0, 2, "t2_rd");

        // Partial strobe over zeroed word.
        wbuf[0] = 64'd0; sbuf[0] = 8'hFF;
        do_write(32'h8, 0, 3'd3, -1, 2'b01, 1'b0, 0, "t3_clr");
        wbuf[0] = 64'h1122_3344_5566_7788; sbuf[0] = 8'h0F;
        do_write(32'h8, 0, 3'd3, -1, 2'b01, 1'b0, 1, "t3_wr");
        do_read(32'h8, 0, 3'd3, 1'b0, 0, 2, "t3_rd");

        // RREADY toggling.
        do_read(32'h40, 7, 3'd3, 1'b1, 1, 2, "t4_rd");

        // Burst running off the top of memory.
        for (int i = 0; i < 4; i++) begin wbuf[i] = {$urandom, $urandom}; sbuf[i] = 8'hFF; end
        do_write(32'h7FF0, 3, 3'd3, -1, 2'b01, 1'b0, 1, "t5_wr");
        do_read(32'h7FF0, 3, 3'd3, 1'b0, 2, 2, "t5_rd");

        // Early WLAST.
        for (int i = 0; i < 4; i++) begin wbuf[i] = {$urandom, $urandom}; sbuf[i] = 8'hFF; end
        do_write(32'h200, 3, 3'd3, 2, 2'b01, 1'b1, 1, "t6_wr");
        do_read(32'h200, 3, 3'd3, 1'b1, 0, 2, "t6_rd");

        // Reset mid-read.
        @(negedge ACLK);
        ARID = 1'b0; ARADDR = 32'h0; ARLEN = 8'd15; ARSIZE = 3'd3; ARVALID = 1'b1;
        n = 0;
        while (ARREADY !== 1'b1 && n < 200) begin @(negedge ACLK); n++; end
        @(negedge ACLK);
        ARVALID = 1'b0; RREADY = 1'b1;
        repeat (4) @(negedge ACLK);
        chk("t6_pre_rvalid", 64'(RVALID), 64'd1);
        #2 ARESETN = 1'b0;
        #1;
        chk("t6_rst_rvalid", 64'(RVALID), 64'd0);
        chk("t6_rst_rlast", 64'(RLAST), 64'd0);
        chk("t6_rst_rdata", RDATA, 64'd0);
        chk("t6_rst_arready", 64'(ARREADY), 64'd0);
        @(negedge ACLK);
        RREADY = 1'b0;
        ARESETN = 1'b1;
        #1;
        chk("t6_rel_arready", 64'(ARREADY), 64'd0);
        do_read(32'h40, 3, 3'd3, 1'b0, 0, 2, "t6_rd2");

        // Size errors: write still lands, every read beat flagged.
        for (int i = 0; i < 2; i++) begin wbuf[i] = {$urandom, $urandom}; sbuf[i] = 8'hFF; end
        do_write(32'h300, 1, 3'd2, -1, 2'b01, 1'b0, 1, "sz_wr");
        do_read(32'h300, 1, 3'd2, 1'b1, 2, -1, "sz_rd");
        do_read(32'h300, 1, 3'd3, 1'b1, 0, -1, "sz_rd_ok");

        // Randomized traffic within the already-written low region.
        for (int t = 0; t < 16; t++) begin
            logic [31:0] a;
            int          l;
            a = 32'($urandom_range(0, 240) * 8) | 32'($urandom_range(0, 7));
            l = $urandom_range(0, 15);
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i <= l; i++) begin
                    wbuf[i] = {$urandom, $urandom};
                    sbuf[i] = 8'($urandom);
                end
                do_write(a, l, 3'd3, -1, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 2,
                         $sformatf("rnd%0d_wr", t));
            end else begin
                do_read(a, l, 3'd3, 1'($urandom_range(0, 1)), 2, -1, $sformatf("rnd%0d_rd", t));
            end
        end
        do_read(32'h0, 255, 3'd3, 1'b0, 2, 2, "final_rd");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
